// File: rtl/signed_frame_accumulator_if.sv
// Valid/ready bundle linking the upstream adder, the frame accumulator and its consumer.
// master = the environment (sample producer + result consumer); slave = the accumulator.
interface signed_frame_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             up_ovf;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_sum;
  logic             down_ovf;

  modport master (
    output up_valid, up_data, up_ovf, down_ready,
    input  up_ready, down_valid, down_sum, down_ovf
  );

  modport slave (
    input  up_valid, up_data, up_ovf, down_ready,
    output up_ready, down_valid, down_sum, down_ovf
  );
endinterface

// File: rtl/signed_frame_accumulator.sv
// Sums FRAME_LEN signed samples into a registered frame total with sticky overflow; result valid 1 cycle after last sample.
// Upstream stalls only when a frame completes while the previous result is still held; SIGNED_FRAME_ACC_SATURATE_EN clamps instead of wrapping.
module signed_frame_accumulator #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  signed_frame_accumulator_if.slave   bus
);
  localparam int            CW   = $clog2(FRAME_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sticky;
  logic             r_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;

  logic             w_last;
  logic             w_fire;
  logic             w_load;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_step_ovf;
  logic             w_sticky_nxt;

  assign w_last       = (r_cnt == LAST);
  // Only the frame-closing sample needs the output register free (or draining now).
  assign bus.up_ready = !(w_last && r_vld && !bus.down_ready);
  assign w_fire       = bus.up_valid && bus.up_ready;
  assign w_load       = w_fire && w_last;

  assign w_nxt        = r_acc + bus.up_data;
  assign w_step_ovf   = (r_acc[WIDTH-1] == bus.up_data[WIDTH-1]) &&
                        (w_nxt[WIDTH-1] != r_acc[WIDTH-1]);
  assign w_sticky_nxt = r_sticky | bus.up_ovf | w_step_ovf;

`ifdef SIGNED_FRAME_ACC_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow only happens with equal signs, so the acc sign picks the rail.
  assign w_acc_nxt = w_step_ovf ? (r_acc[WIDTH-1] ? SMIN : SMAX) : w_nxt;
`else
  assign w_acc_nxt = w_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_vld    <= 1'b0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
        r_sum    <= w_acc_nxt;
        r_ovf    <= w_sticky_nxt;
        r_vld    <= 1'b1;
      end else begin
        if (w_fire) begin
          r_acc    <= w_acc_nxt;
          r_cnt    <= r_cnt + CW'(1);
          r_sticky <= w_sticky_nxt;
        end
        if (r_vld && bus.down_ready) begin
          r_vld <= 1'b0;
        end
      end
    end
  end

  assign bus.down_valid = r_vld;
  assign bus.down_sum   = r_sum;
  assign bus.down_ovf   = r_ovf;
endmodule
